// File: rtl/tricolor_sequencer.sv
// Three-colour LED mode controller: colour table sequencing, per-channel PWM, status byte.
// Optional macro TCL_REVERSE_EN adds the Key_Prev port for backward stepping.
module tricolor_sequencer #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int STEP_MS    = 500,
    parameter int BREATH_DIV = 100_000,
    parameter int PWM_BITS   = 8
) (
    input  logic       Sys_CLK,
    input  logic       Sys_RST,
    input  logic       Key_Next,
    input  logic       Key_Pause,
`ifdef TCL_REVERSE_EN
    input  logic       Key_Prev,
`endif
    input  logic [1:0] Switch,
    output logic       LED_R,
    output logic       LED_G,
    output logic       LED_B,
    output logic       LED_Run,
    output logic [7:0] Disp_Val,
    output logic [2:0] dbg_state
);
    localparam int STEP_CYC = CLK_HZ / 1000 * STEP_MS;
    localparam int STEP_W   = $clog2(STEP_CYC + 1);
    localparam int BR_W     = $clog2(BREATH_DIV + 1);
    localparam logic [PWM_BITS-1:0] DMAX = '1;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_MANUAL  = 3'd1,
        ST_AUTO    = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_BREATHE = 3'd4
    } state_t;

    state_t              state, state_n;
    logic [1:0]          sw_meta, sw_sync;
    logic [2:0]          idx, idx_n, idx_key;
    logic [PWM_BITS-1:0] duty, duty_n, pc;
    logic                dir_down, dir_n;
    logic [STEP_W-1:0]   step_cnt, step_n;
    logic [BR_W-1:0]     breath_cnt, breath_n;
    logic [1:0]          cur_mode;
    logic                mode_chg, key_prev, fwd, back, key_any;
    logic [2:0]          mask;

`ifdef TCL_REVERSE_EN
    assign key_prev = Key_Prev;
`else
    assign key_prev = 1'b0;
`endif

    function automatic logic [2:0] inc_idx(input logic [2:0] i);
        return (i == 3'd5) ? 3'd0 : i + 3'd1;
    endfunction

    function automatic logic [2:0] dec_idx(input logic [2:0] i);
        return (i == 3'd0) ? 3'd5 : i - 3'd1;
    endfunction

    // Bit 0 = R, bit 1 = G, bit 2 = B.
    function automatic logic [2:0] color_mask(input logic [2:0] i);
        case (i)
            3'd0:    return 3'b001;
            3'd1:    return 3'b010;
            3'd2:    return 3'b100;
            3'd3:    return 3'b011;
            3'd4:    return 3'b110;
            3'd5:    return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    assign dbg_state = state;
    assign mask      = color_mask(idx);

    always_comb begin
        case (state)
            ST_MANUAL:           cur_mode = 2'd1;
            ST_AUTO, ST_PAUSED:  cur_mode = 2'd2;
            ST_BREATHE:          cur_mode = 2'd3;
            default:             cur_mode = 2'd0;
        endcase
    end

    // Next and Prev together cancel the index move but still count as a key press.
    assign fwd      = Key_Next & ~key_prev;
    assign back     = key_prev & ~Key_Next;
    assign key_any  = Key_Next | key_prev;
    assign idx_key  = fwd ? inc_idx(idx) : (back ? dec_idx(idx) : idx);
    assign mode_chg = (sw_sync != cur_mode);

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        duty_n   = duty;
        dir_n    = dir_down;
        step_n   = step_cnt;
        breath_n = breath_cnt;
        if (mode_chg) begin
            step_n   = '0;
            breath_n = '0;
            dir_n    = 1'b0;
            case (sw_sync)
                2'd1:    begin state_n = ST_MANUAL;  duty_n = DMAX; end
                2'd2:    begin state_n = ST_AUTO;    duty_n = DMAX; end
                2'd3:    begin state_n = ST_BREATHE; duty_n = '0;   end
                default: begin state_n = ST_OFF;     duty_n = '0;   end
            endcase
        end else begin
            case (state)
                ST_MANUAL: begin
                    duty_n = DMAX;
                    idx_n  = idx_key;
                end
                ST_AUTO: begin
                    duty_n = DMAX;
                    if (key_any) begin
                        idx_n  = idx_key;
                        step_n = '0;
                    end else if (step_cnt == STEP_W'(STEP_CYC - 1)) begin
                        idx_n  = inc_idx(idx);
                        step_n = '0;
                    end else begin
                        step_n = step_cnt + 1'b1;
                    end
                    if (Key_Pause) state_n = ST_PAUSED;
                end
                ST_PAUSED: begin
                    duty_n = DMAX;
                    if (key_any) begin
                        idx_n  = idx_key;
                        step_n = '0;
                    end
                    if (Key_Pause) state_n = ST_AUTO;
                end
                ST_BREATHE: begin
                    if (key_any) idx_n = idx_key;
                    if (breath_cnt == BR_W'(BREATH_DIV - 1)) begin
                        breath_n = '0;
                        if (!dir_down) begin
                            duty_n = duty + 1'b1;
                            if (duty == DMAX - 1'b1) dir_n = 1'b1;
                        end else begin
                            duty_n = duty - 1'b1;
                            // Bottom of the ramp closes one breath and moves to the next colour.
                            if (duty == PWM_BITS'(1)) begin
                                dir_n = 1'b0;
                                if (!key_any) idx_n = inc_idx(idx);
                            end
                        end
                    end else begin
                        breath_n = breath_cnt + 1'b1;
                    end
                end
                default: duty_n = '0;
            endcase
        end
    end

    always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
        if (!Sys_RST) begin
            sw_meta    <= '0;
            sw_sync    <= '0;
            state      <= ST_OFF;
            idx        <= '0;
            duty       <= '0;
            dir_down   <= 1'b0;
            step_cnt   <= '0;
            breath_cnt <= '0;
            pc         <= '0;
            LED_R      <= 1'b0;
            LED_G      <= 1'b0;
            LED_B      <= 1'b0;
            LED_Run    <= 1'b0;
            Disp_Val   <= '0;
        end else begin
            sw_meta    <= Switch;
            sw_sync    <= sw_meta;
            state      <= state_n;
            idx        <= idx_n;
            duty       <= duty_n;
            dir_down   <= dir_n;
            step_cnt   <= step_n;
            breath_cnt <= breath_n;
            pc         <= pc + 1'b1;
            LED_R      <= mask[0] & (pc < duty);
            LED_G      <= mask[1] & (pc < duty);
            LED_B      <= mask[2] & (pc < duty);
            LED_Run    <= (state == ST_AUTO) || (state == ST_BREATHE);
            Disp_Val   <= {2'b00, cur_mode, 1'b0, idx};
        end
    end
endmodule
